// File: rtl/pipelined_add_sub_pkg.sv
// pipelined_add_sub_pkg: shared op encodings and flag bit positions for the add/sub pipeline
package pipelined_add_sub_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_ADC = 2'b10,
        ALU_SBC = 2'b11
    } alu_op_e;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/pipelined_add_sub_if.sv
// pipelined_add_sub_if: operand/result handshake bundle for the pipelined adder/subtractor
interface pipelined_add_sub_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, sum, carry, overflow, zero, negative
    );

endinterface

// File: rtl/pipelined_add_sub_add_segment.sv
// add_segment: SEG-bit ripple adder slice exposing the carry into its top bit for overflow
module add_segment #(parameter int SEG = 4) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    assign c_msb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: segmented-carry add/sub pipeline with N/Z/C/V flags and valid/ready stalling
module pipelined_add_sub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_add_sub_if.slave bus
);

    import pipelined_add_sub_pkg::*;

    localparam int STAGES = WIDTH / SEG;
    localparam int L      = STAGES - 1;

    logic             en, inv, c0;
    logic             s_v [STAGES];
    logic             s_c [STAGES];
    logic [WIDTH-1:0] s_a [STAGES];
    logic [WIDTH-1:0] s_b [STAGES];
    logic [WIDTH-1:0] s_ps[STAGES];
    logic [WIDTH-1:0] m_ps[STAGES];
    logic             r_v [STAGES];
    logic             r_c [STAGES];
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_ps[STAGES];
    logic [SEG-1:0]   seg_sum [STAGES];
    logic             seg_cout[STAGES];
    logic             seg_cmsb[STAGES];
    logic             out_valid, carry, overflow, zero, negative;
    logic [WIDTH-1:0] sum;

    assign en           = ~(out_valid & ~bus.out_ready);
    assign bus.in_ready = rst_n & en;
    assign inv          = (bus.op == ALU_SUB) || (bus.op == ALU_SBC);
    assign c0           = ((bus.op == ALU_ADC) || (bus.op == ALU_SBC)) ? bus.cin : inv;

    // Stage inputs: stage 0 sees the incoming beat, later stages their skew registers
    always_comb begin
        s_v[0]  = bus.in_valid;
        s_a[0]  = bus.a;
        s_b[0]  = inv ? ~bus.b : bus.b;
        s_c[0]  = c0;
        s_ps[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            s_v[k]  = r_v[k];
            s_a[k]  = r_a[k];
            s_b[k]  = r_b[k];
            s_c[k]  = r_c[k];
            s_ps[k] = r_ps[k];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_seg
        add_segment #(.SEG(SEG)) u_seg (
            .a     (s_a[i][i*SEG +: SEG]),
            .b     (s_b[i][i*SEG +: SEG]),
            .cin   (s_c[i]),
            .sum   (seg_sum[i]),
            .cout  (seg_cout[i]),
            .c_msb (seg_cmsb[i])
        );
    end

    // Splice each stage's freshly resolved segment into the partial sum it carries
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            m_ps[k]                = s_ps[k];
            m_ps[k][k*SEG +: SEG]  = seg_sum[k];
        end
    end

    // Skew registers advance together, bubbles included, unless the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]  <= 1'b0;
                r_c[k]  <= 1'b0;
                r_a[k]  <= '0;
                r_b[k]  <= '0;
                r_ps[k] <= '0;
            end
        end else if (en) begin
            for (int k = 1; k < STAGES; k++) begin
                r_v[k]  <= s_v[k-1];
                r_c[k]  <= seg_cout[k-1];
                r_a[k]  <= s_a[k-1];
                r_b[k]  <= s_b[k-1];
                r_ps[k] <= m_ps[k-1];
            end
        end
    end

    // Final stage registers the assembled sum and flags, touching data only for valid beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (en) begin
            out_valid <= s_v[L];
            if (s_v[L]) begin
                sum      <= m_ps[L];
                carry    <= seg_cout[L];
                overflow <= seg_cout[L] ^ seg_cmsb[L];
                zero     <= m_ps[L] == '0;
                negative <= m_ps[L][WIDTH-1];
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.sum       = sum;
    assign bus.carry     = carry;
    assign bus.overflow  = overflow;
    assign bus.zero      = zero;
    assign bus.negative  = negative;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed and random checks of 4-stage and single-stage builds against an arithmetic model
module tb_pipelined_add_sub;

    import pipelined_add_sub_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    logic [19:0] q4[$];
    logic [19:0] q16[$];
    logic acc4  = 1'b0;
    logic acc16 = 1'b0;

    pipelined_add_sub_if #(.WIDTH(16)) bus4 ();
    pipelined_add_sub_if #(.WIDTH(16)) bus16 ();

    pipelined_add_sub #(.WIDTH(16), .SEG(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    pipelined_add_sub #(.WIDTH(16), .SEG(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op, input logic cin);
        int ua, ub, sa, sb, ci, r, sr;
        logic [15:0] s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = int'(cin);
        case (op)
            ALU_ADD: begin r = ua + ub;              sr = sa + sb;          end
            ALU_SUB: begin r = ua + 65536 - ub;      sr = sa - sb;          end
            ALU_ADC: begin r = ua + ub + ci;         sr = sa + sb + ci;     end
            default: begin r = ua + 65535 - ub + ci; sr = sa - sb - 1 + ci; end
        endcase
        s = r[15:0];
        return {s[15], s == 16'h0, r >= 65536, (sr > 32767) || (sr < -32768), s};
    endfunction

    function automatic logic [19:0] obs4();
        logic [3:0] f;
        f[FLAG_N] = bus4.negative;
        f[FLAG_Z] = bus4.zero;
        f[FLAG_C] = bus4.carry;
        f[FLAG_V] = bus4.overflow;
        return {f, bus4.sum};
    endfunction

    function automatic logic [19:0] obs16();
        logic [3:0] f;
        f[FLAG_N] = bus16.negative;
        f[FLAG_Z] = bus16.zero;
        f[FLAG_C] = bus16.carry;
        f[FLAG_V] = bus16.overflow;
        return {f, bus16.sum};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rnd4();
        bus4.a   = 16'($urandom);
        bus4.b   = ($urandom_range(0, 7) == 0) ? bus4.a : 16'($urandom);
        bus4.op  = 2'($urandom);
        bus4.cin = 1'($urandom);
    endtask

    task automatic rnd16();
        bus16.a   = 16'($urandom);
        bus16.b   = ($urandom_range(0, 7) == 0) ? bus16.a : 16'($urandom);
        bus16.op  = 2'($urandom);
        bus16.cin = 1'($urandom);
    endtask

    task automatic tick();
        #1;
        if (bus4.out_valid && bus4.out_ready) begin
            chk("u4_result_expected", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) chk("u4_result", 32'(obs4()), 32'(q4.pop_front()));
        end
        if (bus16.out_valid && bus16.out_ready) begin
            chk("u16_result_expected", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) chk("u16_result", 32'(obs16()), 32'(q16.pop_front()));
        end
        acc4  = bus4.in_valid && bus4.in_ready;
        acc16 = bus16.in_valid && bus16.in_ready;
        if (acc4)  q4.push_back(model(bus4.a, bus4.b, bus4.op, bus4.cin));
        if (acc16) q16.push_back(model(bus16.a, bus16.b, bus16.op, bus16.cin));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] op, input logic cin, input logic [19:0] exp);
        bus4.a  = a;  bus4.b  = b;  bus4.op  = op;  bus4.cin  = cin;
        bus16.a = a;  bus16.b = b;  bus16.op = op;  bus16.cin = cin;
        bus4.in_valid  = 1'b1;
        bus16.in_valid = 1'b1;
        bus4.out_ready  = 1'b1;
        bus16.out_ready = 1'b1;
        tick();
        bus4.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        chk({tag, "_accepted"}, 32'(acc4 && acc16), 32'd1);
        chk({tag, "_u16_valid"}, 32'(bus16.out_valid), 32'd1);
        chk({tag, "_u16_value"}, 32'(obs16()), 32'(exp));
        chk({tag, "_u4_early1"}, 32'(bus4.out_valid), 32'd0);
        tick();
        tick();
        chk({tag, "_u4_early3"}, 32'(bus4.out_valid), 32'd0);
        tick();
        chk({tag, "_u4_valid"}, 32'(bus4.out_valid), 32'd1);
        chk({tag, "_u4_value"}, 32'(obs4()), 32'(exp));
        tick();
    endtask

    initial begin
        int          idx;
        int          stall_left;
        logic        seen;
        logic [19:0] snap;

        bus4.in_valid = 1'b0;  bus4.out_ready = 1'b1;  bus4.a = '0;  bus4.b = '0;  bus4.op = '0;  bus4.cin = 1'b0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.a = '0; bus16.b = '0; bus16.op = '0; bus16.cin = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_u4_valid",  32'(bus4.out_valid), 32'd0);
        chk("rst_u4_ready",  32'(bus4.in_ready),  32'd0);
        chk("rst_u4_data",   32'(obs4()),         32'd0);
        chk("rst_u16_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst_u16_ready", 32'(bus16.in_ready),  32'd0);
        chk("rst_u16_data",  32'(obs16()),         32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_u4_ready",  32'(bus4.in_ready),  32'd1);
        chk("rel_u16_ready", 32'(bus16.in_ready), 32'd1);

        directed("add_ovf",   16'h7FFF, 16'h0001, ALU_ADD, 1'b0, 20'h98000);
        directed("sub_borrow", 16'h0000, 16'h0001, ALU_SUB, 1'b0, 20'h8FFFF);
        directed("sub_ovf",   16'h8000, 16'h0001, ALU_SUB, 1'b0, 20'h37FFF);
        directed("add_zero",  16'hFFFF, 16'h0001, ALU_ADD, 1'b0, 20'h60000);
        directed("adc_cin",   16'h1234, 16'h0000, ALU_ADC, 1'b1, 20'h01235);
        directed("sbc_cin0",  16'h0005, 16'h0003, ALU_SBC, 1'b0, 20'h20001);

        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        idx = 0;
        seen = 1'b0;
        stall_left = 0;
        snap = '0;
        rnd4();
        for (int c = 0; c < 40; c++) begin
            bus4.in_valid = idx < 8;
            if (bus4.out_valid && !seen) begin
                seen = 1'b1;
                stall_left = 3;
                snap = obs4();
            end
            bus4.out_ready = stall_left == 0;
            if (stall_left > 0) begin
                #1;
                chk("stall_in_ready", 32'(bus4.in_ready), 32'd0);
                if (stall_left < 3) begin
                    chk("stall_hold_valid", 32'(bus4.out_valid), 32'd1);
                    chk("stall_hold_data",  32'(obs4()),         32'(snap));
                end
                stall_left--;
            end
            tick();
            if (acc4) begin
                idx++;
                rnd4();
            end
        end
        chk("stall_seen",     32'(seen), 32'd1);
        chk("stall_all_sent", 32'(idx),  32'd8);
        chk("stall_drained",  32'(q4.size()), 32'd0);

        bus4.out_ready  = 1'b1;
        bus16.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rnd4();
            rnd16();
            bus4.in_valid  = 1'b1;
            bus16.in_valid = 1'b1;
            tick();
        end
        bus4.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        chk("midrst_pre_valid", 32'(bus4.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_u4_valid",  32'(bus4.out_valid),  32'd0);
        chk("midrst_u4_ready",  32'(bus4.in_ready),   32'd0);
        chk("midrst_u4_data",   32'(obs4()),          32'd0);
        chk("midrst_u16_valid", 32'(bus16.out_valid), 32'd0);
        q4.delete();
        q16.delete();
        @(posedge clk);
        #4 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("midrst_quiet_u4",  32'(bus4.out_valid),  32'd0);
            chk("midrst_quiet_u16", 32'(bus16.out_valid), 32'd0);
        end
        directed("post_rst", 16'h0001, 16'h0001, ALU_ADD, 1'b0, 20'h00002);

        for (int c = 0; c < 300; c++) begin
            if (!bus4.in_valid || acc4) begin
                rnd4();
                bus4.in_valid = $urandom_range(0, 3) != 0;
            end
            if (!bus16.in_valid || acc16) begin
                rnd16();
                bus16.in_valid = $urandom_range(0, 3) != 0;
            end
            bus4.out_ready  = $urandom_range(0, 3) != 0;
            bus16.out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        bus4.in_valid   = 1'b0;
        bus16.in_valid  = 1'b0;
        bus4.out_ready  = 1'b1;
        bus16.out_ready = 1'b1;
        repeat (12) tick();
        chk("sweep_u4_drained",  32'(q4.size()),  32'd0);
        chk("sweep_u16_drained", 32'(q16.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
